// File: rtl/montgomery_mul_r2_pkg.sv
// Shared RSA datapath definitions: default operand width and the Montgomery
// multiplier state encoding, also used by the exponentiation controller.
package rsa_pkg;

    localparam int unsigned RSA_WIDTH = 512;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOOP = 2'd1,
        ST_SUB  = 2'd2,
        ST_DONE = 2'd3
    } mont_state_e;

endpackage

// File: rtl/montgomery_mul_r2_if.sv
// Request/response bundle for the radix-2 Montgomery multiplier.
interface montgomery_mul_r2_if
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = RSA_WIDTH
) ();

    logic             start;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic [WIDTH-1:0] in_m;
    logic [WIDTH-1:0] result;
    logic             done;

    modport master (
        output start, in_a, in_b, in_m,
        input  result, done
    );

    modport slave (
        input  start, in_a, in_b, in_m,
        output result, done
    );

endinterface

// File: rtl/montgomery_mul_r2_cond_sub.sv
// Final Montgomery reduction step: bring an accumulator known to be < 2m into [0, m).
module mont_cond_sub
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = RSA_WIDTH
) (
    input  logic [WIDTH+1:0] c_i,
    input  logic [WIDTH-1:0] m_i,
    output logic [WIDTH-1:0] r_o
);

    logic [WIDTH+1:0] m_ext;

    always_comb begin
        m_ext = {2'b00, m_i};
        r_o   = (c_i >= m_ext) ? WIDTH'(c_i - m_ext) : c_i[WIDTH-1:0];
    end

endmodule

// File: rtl/montgomery_mul_r2.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m,
// one multiplier bit per cycle, WIDTH+2 edges from accepted start to done.
module montgomery_mul_r2
    import rsa_pkg::*;
#(
    parameter int unsigned WIDTH = RSA_WIDTH
) (
    input  logic               clk,
    input  logic               resetn,
    montgomery_mul_r2_if.slave bus
);

    localparam int unsigned IW = $clog2(WIDTH);
    localparam int unsigned CW = WIDTH + 2;

    mont_state_e      state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] m_q;
    logic [WIDTH-1:0] result_q;
    logic [CW-1:0]    c_q;
    logic [CW-1:0]    c_d;
    logic [IW-1:0]    i_q;
    logic             done_q;
    logic [CW-1:0]    t_add;
    logic [CW-1:0]    t_red;
    logic [WIDTH-1:0] reduced;

    // Two guard bits keep C + b + m below 2^(WIDTH+2) while C < 2m holds.
    always_comb begin
        t_add = c_q + (a_q[i_q] ? {2'b00, b_q} : '0);
        t_red = t_add + (t_add[0] ? {2'b00, m_q} : '0);
        c_d   = t_red >> 1;
    end

    mont_cond_sub #(
        .WIDTH (WIDTH)
    ) u_cond_sub (
        .c_i (c_q),
        .m_i (m_q),
        .r_o (reduced)
    );

    always_ff @(posedge clk or posedge resetn) begin
        if (resetn) begin
            state_q  <= ST_IDLE;
            a_q      <= '0;
            b_q      <= '0;
            m_q      <= '0;
            c_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                // done is still high in the first IDLE cycle; a start there is dropped.
                ST_IDLE: begin
                    if (bus.start && !done_q) begin
                        a_q     <= bus.in_a;
                        b_q     <= bus.in_b;
                        m_q     <= bus.in_m;
                        c_q     <= '0;
                        i_q     <= '0;
                        state_q <= ST_LOOP;
                    end
                end
                ST_LOOP: begin
                    c_q <= c_d;
                    i_q <= i_q + IW'(1);
                    if (i_q == IW'(WIDTH - 1)) begin
                        state_q <= ST_SUB;
                    end
                end
                ST_SUB: begin
                    result_q <= reduced;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    done_q  <= 1'b1;
                    state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign bus.result = result_q;
    assign bus.done   = done_q;

endmodule

// File: tb/tb_montgomery_mul_r2.sv
// Directed bench for montgomery_mul_r2 at WIDTH=8 and WIDTH=512.
module tb_montgomery_mul_r2;

    localparam int unsigned W8 = 8;
    localparam int unsigned WL = 512;

    logic clk    = 1'b0;
    logic resetn = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    montgomery_mul_r2_if #(.WIDTH(W8)) if8 ();
    montgomery_mul_r2_if #(.WIDTH(WL)) ifl ();

    montgomery_mul_r2 #(.WIDTH(W8)) u_dut8 (
        .clk    (clk),
        .resetn (resetn),
        .bus    (if8.slave)
    );

    montgomery_mul_r2 #(.WIDTH(WL)) u_dutl (
        .clk    (clk),
        .resetn (resetn),
        .bus    (ifl.slave)
    );

    task automatic check(input string tag, input logic [511:0] got, input logic [511:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Edge 0 samples start; done is looked at 1ns after each later edge.
    task automatic run8(input logic [7:0] a, input logic [7:0] b, input logic [7:0] m,
                        input int xs0, input int xs1, input int rst_at,
                        output int first_done, output int n_done);
        first_done = -1;
        n_done     = 0;
        @(negedge clk);
        if8.in_a  = a;
        if8.in_b  = b;
        if8.in_m  = m;
        if8.start = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= 24; e++) begin
            @(negedge clk);
            if8.in_a  = ~a;
            if8.in_b  = ~b;
            if8.in_m  = ~m;
            if8.start = (e == xs0) || (e == xs1);
            resetn    = (e == rst_at);
            @(posedge clk);
            #1;
            if (if8.done) begin
                n_done++;
                if (first_done < 0) first_done = e;
            end
        end
        if8.start = 1'b0;
    endtask

    task automatic runl(input logic [511:0] a, input logic [511:0] b, input logic [511:0] m,
                        output int first_done, output int n_done);
        first_done = -1;
        n_done     = 0;
        @(negedge clk);
        ifl.in_a  = a;
        ifl.in_b  = b;
        ifl.in_m  = m;
        ifl.start = 1'b1;
        @(posedge clk);
        for (int e = 1; e <= int'(WL) + 8; e++) begin
            @(negedge clk);
            ifl.start = 1'b0;
            ifl.in_a  = ~a;
            ifl.in_b  = ~b;
            ifl.in_m  = ~m;
            @(posedge clk);
            #1;
            if (ifl.done) begin
                n_done++;
                if (first_done < 0) first_done = e;
            end
        end
    endtask

    function automatic logic [511:0] rand512();
        logic [511:0] v;
        for (int k = 0; k < 16; k++) v[32*k +: 32] = $urandom;
        return v;
    endfunction

    initial begin
        int           fd;
        int           nd;
        logic [511:0] mbig;
        logic [511:0] p510;
        logic [511:0] ra;
        logic [511:0] rb;
        logic [511:0] rm;
        logic [1535:0] w_m;
        logic [1535:0] w_ab;
        logic [1535:0] w_r;

        if8.start = 1'b0; if8.in_a = '0; if8.in_b = '0; if8.in_m = '0;
        ifl.start = 1'b0; ifl.in_a = '0; ifl.in_b = '0; ifl.in_m = '0;
        repeat (3) @(posedge clk);
        #1;
        check("rst8_done",   if8.done,   0);
        check("rst8_result", if8.result, 0);
        check("rstl_done",   ifl.done,   0);
        check("rstl_result", ifl.result, 0);
        @(negedge clk);
        resetn = 1'b0;
        repeat (2) @(posedge clk);

        run8(8'd5, 8'd7, 8'd13, -1, -1, -1, fd, nd);
        check("basic_lat", fd, 10);
        check("basic_ndone", nd, 1);
        check("basic_res", if8.result, 1);

        run8(8'd254, 8'd254, 8'd255, -1, -1, -1, fd, nd);
        check("maxacc_lat", fd, 10);
        check("maxacc_res", if8.result, 1);

        run8(8'd12, 8'd12, 8'd13, -1, -1, -1, fd, nd);
        check("m13_12x12", if8.result, 3);

        run8(8'd0, 8'd7, 8'd13, -1, -1, -1, fd, nd);
        check("a0_lat", fd, 10);
        check("a0_res", if8.result, 0);

        run8(8'd5, 8'd0, 8'd13, -1, -1, -1, fd, nd);
        check("b0_res", if8.result, 0);

        run8(8'd1, 8'd1, 8'd13, -1, -1, -1, fd, nd);
        check("m13_1x1", if8.result, 3);

        run8(8'd12, 8'd1, 8'd13, -1, -1, -1, fd, nd);
        check("m13_12x1", if8.result, 10);

        run8(8'd5, 8'd7, 8'd13, 4, 11, -1, fd, nd);
        check("restart_ndone", nd, 1);
        check("restart_lat", fd, 10);
        check("restart_res", if8.result, 1);

        run8(8'd12, 8'd12, 8'd13, -1, -1, 5, fd, nd);
        check("abort_ndone", nd, 0);
        check("abort_res", if8.result, 0);

        run8(8'd12, 8'd12, 8'd13, -1, -1, -1, fd, nd);
        check("post_abort_lat", fd, 10);
        check("post_abort_res", if8.result, 3);

        run8(8'd5, 8'd7, 8'd12, -1, -1, -1, fd, nd);
        check("even_m_lat", fd, 10);
        check("even_m_ndone", nd, 1);

        mbig      = '0;
        mbig[511] = 1'b1;
        mbig[0]   = 1'b1;
        p510      = '0;
        p510[510] = 1'b1;

        runl('0, rand512(), mbig, fd, nd);
        check("w512_a0_lat", fd, 514);
        check("w512_a0_ndone", nd, 1);
        check("w512_a0_res", ifl.result, 0);

        runl(512'd1, 512'd1, mbig, fd, nd);
        check("w512_1x1", ifl.result, p510);

        runl(p510 << 1, 512'd1, mbig, fd, nd);
        check("w512_half", ifl.result, p510 + 512'd1);

        for (int v = 0; v < 16; v++) begin
            rm      = rand512();
            rm[0]   = 1'b1;
            rm[511] = (v % 2 == 0);
            ra      = rand512() % rm;
            rb      = rand512() % rm;
            runl(ra, rb, rm, fd, nd);
            w_m  = {1024'd0, rm};
            w_ab = ({1024'd0, ra} * {1024'd0, rb}) % w_m;
            w_r  = ({1024'd0, ifl.result} << WL) % w_m;
            check("rnd_lat", fd, 514);
            check("rnd_congruent", w_r[511:0], w_ab[511:0]);
            check("rnd_below_m", ifl.result < rm, 1);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
